mp_regfile: RTL

MP_REGFILE -- requirements
Module: mp_regfile

---
 rtl/mp_regfile.sv | 138 +++++++++++++
 1 files changed

// File: rtl/mp_regfile.sv
// mp_regfile: register file with two write ports, two combinational read ports and a bulk-clear sweep.
// Optional same-cycle write-to-read forwarding is enabled by defining MP_REGFILE_BYPASS_EN.
module mp_regfile #(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 3,
    parameter bit ZERO_REG = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we3,
    input  logic              we4,
    input  logic [ADDR_W-1:0] wa3,
    input  logic [ADDR_W-1:0] wa4,
    input  logic [DATA_W-1:0] wd3,
    input  logic [DATA_W-1:0] wd4,
    input  logic [ADDR_W-1:0] ra1,
    input  logic [ADDR_W-1:0] ra2,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2,
    input  logic              clr_req,
    output logic              clr_busy,
    output logic              clr_done
);

    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_DONE
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] ptr;
    logic [ADDR_W-1:0] ptr_nxt;
    logic [DATA_W-1:0] regs [DEPTH];

    logic idle;
    logic sweep_last;
    logic wr3_ok;
    logic wr4_ok;
    logic ra1_zero;
    logic ra2_zero;

    assign idle       = (state == ST_IDLE);
    assign sweep_last = (ptr == ADDR_W'(DEPTH - 1));

    // Writes are accepted only in IDLE; the hard-wired zero entry swallows writes.
    assign wr3_ok   = we3 && idle && !(ZERO_REG && (wa3 == '0));
    assign wr4_ok   = we4 && idle && !(ZERO_REG && (wa4 == '0));
    assign ra1_zero = ZERO_REG && (ra1 == '0);
    assign ra2_zero = ZERO_REG && (ra2 == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            ptr   <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            state <= state_nxt;
            ptr   <= ptr_nxt;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves one unassigned (no latch).
        state_nxt = state;
        ptr_nxt   = ptr;
        clr_busy  = 1'b0;
        clr_done  = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (clr_req) begin
                    state_nxt = ST_CLEAR;
                    ptr_nxt   = '0;
                end
            end
            ST_CLEAR: begin
                clr_busy = 1'b1;
                ptr_nxt  = ptr + 1'b1;
                if (sweep_last) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                clr_done  = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the array is reset because reads must return zero during and after reset.
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else begin
            if (state == ST_CLEAR) begin
                regs[ptr] <= '0;
            end
            // Port 4 is assigned last so it wins a same-address collision.
            if (wr3_ok) begin
                regs[wa3] <= wd3;
            end
            if (wr4_ok) begin
                regs[wa4] <= wd4;
            end
        end
    end

    always_comb begin
        rd1 = ra1_zero ? '0 : regs[ra1];
`ifdef MP_REGFILE_BYPASS_EN
        if (rst_n && wr4_ok && (wa4 == ra1)) begin
            rd1 = wd4;
        end else if (rst_n && wr3_ok && (wa3 == ra1)) begin
            rd1 = wd3;
        end
`endif
    end

    always_comb begin
        rd2 = ra2_zero ? '0 : regs[ra2];
`ifdef MP_REGFILE_BYPASS_EN
        if (rst_n && wr4_ok && (wa4 == ra2)) begin
            rd2 = wd4;
        end else if (rst_n && wr3_ok && (wa3 == ra2)) begin
            rd2 = wd3;
        end
`endif
    end

endmodule
